sort_tree_ctrl: RTL and testbench

//  Sequencer for one Sorting_Tree instance. Runs the tree's hold/is_input

---
 rtl/sort_pkg.sv | 11 +
 rtl/sort_flush_timer.sv | 28 ++
 rtl/sort_tree_ctrl.sv | 129 ++++++++++++
 tb/tb_sort_tree_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and helpers for the sort tree sequencer blocks
// State encoding and counter width helper used by sort_tree_ctrl and later sort blocks.
package sort_pkg;

  typedef enum logic [1:0] {FLUSH, LOAD, TURN, DRAIN} sort_state_e;

  function automatic int cnt_w(input int r_sz);
    return $clog2(r_sz + 1);
  endfunction

endpackage

// File: rtl/sort_flush_timer.sv
// rtl/sort_flush_timer.sv - loadable down-counter, done while the count sits at zero
// Holds at zero until reloaded; en only decrements a non-zero count.
module sort_flush_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sort_tree_ctrl.sv
// rtl/sort_tree_ctrl.sv - hold/is_input sequencer for one Sorting_Tree instance
// Flushes the reset-less tree, loads one frame from s_*, then drains it sorted to m_*.
module sort_tree_ctrl
  import sort_pkg::*;
#(
  parameter int HBIT      = 15,
  parameter int R_SZ      = 256,
  parameter int FLUSH_CYC = R_SZ,
  parameter bit ASCEND    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [HBIT:0]            s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [HBIT:0]            m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic [cnt_w(R_SZ)-1:0]   count,
  output logic                     tree_hold,
  output logic                     tree_is_input,
  output logic [HBIT:0]            tree_din,
  input  logic [HBIT:0]            tree_dout
);

  localparam int CW = cnt_w(R_SZ);
  localparam int TW = cnt_w(FLUSH_CYC);
  localparam logic [CW-1:0] FULL = CW'(R_SZ);
  localparam logic [CW-1:0] ONE  = CW'(1);
  // First FLUSH cycle arms the timer, so it is loaded two short of FLUSH_CYC.
  localparam logic [TW-1:0] FLUSH_LOAD = TW'(FLUSH_CYC - 2);

  sort_state_e state, next_state;
  logic        flush_start;
  logic        timer_load;
  logic        timer_done;
  logic        push;
  logic        pop;

  sort_flush_timer #(.W(TW)) u_flush_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (FLUSH_LOAD),
    .en       ((state == FLUSH) && !flush_start),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FLUSH;
      count       <= '0;
      flush_start <= 1'b1;
    end else begin
      state <= next_state;
      if (push) begin
        count <= count + ONE;
      end else if (pop) begin
        count <= count - ONE;
      end
      if (timer_load) begin
        flush_start <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state    = state;
    s_ready       = 1'b0;
    m_valid       = 1'b0;
    m_last        = 1'b0;
    busy          = 1'b1;
    tree_hold     = 1'b1;
    tree_is_input = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    timer_load    = 1'b0;
    case (state)
      FLUSH: begin
        tree_hold = 1'b0;
        if (flush_start) begin
          timer_load = 1'b1;
        end else if (timer_done) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        s_ready = (count < FULL);
        busy    = (count != '0);
        if (s_valid && s_ready) begin
          push          = 1'b1;
          tree_hold     = 1'b0;
          tree_is_input = 1'b1;
          if (s_last || (count == FULL - ONE)) begin
            next_state = TURN;
          end
        end
      end
      TURN: begin
        next_state = DRAIN;
      end
      DRAIN: begin
        m_valid = (count != '0);
        m_last  = m_valid && (count == ONE);
        if (m_valid && m_ready) begin
          pop       = 1'b1;
          tree_hold = 1'b0;
          if (count == ONE) begin
            next_state = LOAD;
          end
        end
      end
      default: begin
        next_state = FLUSH;
      end
    endcase
  end

  // Inverting both directions turns the tree's largest-first order into smallest-first.
  assign tree_din = ASCEND ? ~s_data : s_data;
  assign m_data   = ASCEND ? ~tree_dout : tree_dout;

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL);
  a_no_under:  assert property (@(posedge clk) disable iff (!rst_n) !(pop && (count == '0)));

endmodule

// File: tb/tb_sort_tree_ctrl.sv
// tb/tb_sort_tree_ctrl.sv - bench for sort_tree_ctrl driving two behavioural trees
// Instance 0 runs ASCEND=0 and instance 1 ASCEND=1 from the same stream stimulus.
module tb_sort_tree_ctrl;
  localparam int R_SZ = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;

  logic        s_ready [2];
  logic        m_valid [2];
  logic [15:0] m_data [2];
  logic        m_last [2];
  logic        busy [2];
  logic [8:0]  count [2];
  logic        tree_hold [2];
  logic        tree_is_input [2];
  logic [15:0] tree_din [2];

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int max_idx(input logic [15:0] q[$]);
    int k = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] > q[k]) k = i;
    return k;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] tq[$];
    logic [15:0] dout = '0;

    sort_tree_ctrl #(.HBIT(15), .R_SZ(R_SZ), .FLUSH_CYC(R_SZ), .ASCEND(g == 1)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_valid       (s_valid),
      .s_ready       (s_ready[g]),
      .s_data        (s_data),
      .s_last        (s_last),
      .m_valid       (m_valid[g]),
      .m_ready       (m_ready),
      .m_data        (m_data[g]),
      .m_last        (m_last[g]),
      .busy          (busy[g]),
      .count         (count[g]),
      .tree_hold     (tree_hold[g]),
      .tree_is_input (tree_is_input[g]),
      .tree_din      (tree_din[g]),
      .tree_dout     (dout)
    );

    // Tree model: unheld cycles push (is_input) or pop the largest; output is the registered max.
    always @(posedge clk) begin
      if (!tree_hold[g]) begin
        if (tree_is_input[g]) tq.push_back(tree_din[g]);
        else if (tq.size() > 0) tq.delete(max_idx(tq));
      end
      dout <= (tq.size() > 0) ? tq[max_idx(tq)] : 16'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic last, input int gap_max);
    bit ok = 0;
    repeat ($urandom_range(0, gap_max)) begin
      s_valid = 1'b0;
      @(negedge clk);
      check("load_idle_hold0", tree_hold[0], 1);
      check("load_idle_hold1", tree_hold[1], 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_ready[0]) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [15:0] w [4];
    logic [15:0] desc [4];
    logic [15:0] asc [4];
  } vec_t;
  vec_t tbl [3];

  task automatic run_table(input vec_t v);
    m_ready = 1'b1;
    for (int i = 0; i < v.n; i++) push_word(v.w[i], i == v.n - 1, 0);
    @(negedge clk);
    check("turn_m_valid", m_valid[0], 0);
    check("turn_hold", tree_hold[0], 1);
    @(posedge clk); #1;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      check("tbl_m_valid", m_valid[0], 1);
      check("tbl_desc", m_data[0], v.desc[i]);
      check("tbl_asc", m_data[1], v.asc[i]);
      check("tbl_m_last", m_last[0], i == v.n - 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("reload_s_ready", s_ready[0], 1);
    check("reload_busy", busy[0], 0);
    check("reload_count", count[0], 0);
    @(posedge clk); #1;
  endtask

  task automatic run_rand(input int n, input logic use_last, input int gap_max, input int rdy_pct);
    logic [15:0] words[$];
    logic [15:0] desc[$];
    logic [15:0] asc[$];
    logic [15:0] held0, held1;
    bit stalled = 0;
    int got = 0;
    for (int i = 0; i < n; i++) words.push_back(16'($urandom()));
    desc = words; desc.rsort();
    asc = words; asc.sort();
    for (int i = 0; i < n; i++) push_word(words[i], use_last && (i == n - 1), gap_max);
    @(negedge clk);
    check("turn_s_ready", s_ready[0], 0);
    @(posedge clk); #1;
    for (int t = 0; t < 20000 && got < n; t++) begin
      m_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (m_valid[0] && m_ready) begin
        check("rnd_desc", m_data[0], desc[got]);
        check("rnd_asc", m_data[1], asc[got]);
        check("rnd_m_last", m_last[0], got == n - 1);
        got++;
        stalled = 0;
      end else if (m_valid[0]) begin
        if (stalled) begin
          check("stall_stable0", m_data[0], held0);
          check("stall_stable1", m_data[1], held1);
        end
        check("stall_hold0", tree_hold[0], 1);
        check("stall_hold1", tree_hold[1], 1);
        held0 = m_data[0]; held1 = m_data[1];
        stalled = 1;
      end
      @(posedge clk); #1;
    end
    check("drain_words", got, n);
    m_ready = 1'b1;
    @(negedge clk);
    check("end_count", count[0], 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, bad;
    bit ok;
    tbl[0] = '{4, '{5, 3, 9, 1}, '{9, 5, 3, 1}, '{1, 3, 5, 9}};
    tbl[1] = '{3, '{7, 7, 2, 0}, '{7, 7, 2, 0}, '{2, 7, 7, 0}};
    tbl[2] = '{2, '{4, 8, 0, 0}, '{8, 4, 0, 0}, '{4, 8, 0, 0}};

    #3;
    check("rst_s_ready", s_ready[0], 0);
    check("rst_m_valid", m_valid[0], 0);
    check("rst_m_last", m_last[0], 0);
    check("rst_busy", busy[0], 1);
    check("rst_count", count[0], 0);
    check("rst_hold", tree_hold[0], 0);
    check("rst_is_input", tree_is_input[0], 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0; bad = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (s_ready[0]) break;
      cyc++;
      if (tree_hold[0] || tree_is_input[0] || tree_hold[1] || tree_is_input[1]) bad++;
    end
    check("flush_cycles", cyc, 256);
    check("flush_pins", bad, 0);
    check("post_flush_s_ready", s_ready[0], 1);
    check("post_flush_busy", busy[0], 0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) run_table(tbl[i]);

    for (int f = 0; f < 6; f++) run_rand($urandom_range(1, 24), 1'b1, 2, 60);

    run_rand(R_SZ, 1'b0, 0, 70);

    for (int i = 0; i < 150; i++) push_word(16'($urandom()), i == 149, 0);
    m_ready = 1'b1;
    repeat (51) @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    check("mid_count", count[0], 100);
    check("mid_m_valid", m_valid[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_m_valid0", m_valid[0], 0);
    check("arst_m_valid1", m_valid[1], 0);
    check("arst_s_ready", s_ready[0], 0);
    check("arst_busy", busy[0], 1);
    check("arst_count", count[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    ok = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (m_valid[0]) bad++;
      if (s_ready[0]) begin ok = 1; break; end
    end
    check("reflush_done", ok, 1);
    @(posedge clk); #1;
    run_table(tbl[2]);
    repeat (3) begin
      @(negedge clk);
      check("no_stale_m_valid", m_valid[0], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
